// File: rtl/cache_refill_ctrl.sv
// Miss-path line refill controller: fetches a 4-word line over a req/ack word port and
// presents a single fill beat. Optional critical-word-first ordering via CRITICAL_WORD_FIRST_EN.
module cache_refill_ctrl #(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned TAG_WIDTH      = 8,
  parameter int unsigned INDEX_WIDTH    = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 miss_req_i,
  input  logic [ADDRESS_WIDTH-1:0]             miss_addr_i,
  output logic                                 stall_o,
  output logic                                 busy_o,
  output logic                                 mem_req_o,
  output logic [ADDRESS_WIDTH-1:0]             mem_addr_o,
  input  logic                                 mem_ack_i,
  input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
  output logic                                 fill_valid_o,
  output logic [TAG_WIDTH-1:0]                 fill_tag_o,
  output logic [INDEX_WIDTH-1:0]               fill_index_o,
  output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] fill_line_o,
  output logic                                 crit_valid_o,
  output logic [DATA_WIDTH-1:0]                crit_data_o
);

  localparam int unsigned LineWidth = DATA_WIDTH * WORDS_PER_LINE;
  localparam int unsigned BaseWidth = ADDRESS_WIDTH - 4;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StFill  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [BaseWidth-1:0] base_q, base_d;
  logic [1:0]           off_q, off_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [LineWidth-1:0] line_q, line_d;
  logic [1:0]           start_off;
  logic                 ack_fire;

  assign ack_fire = (state_q == StFetch) && mem_ack_i;

`ifdef CRITICAL_WORD_FIRST_EN
  logic                  crit_valid_q, crit_valid_d;
  logic [DATA_WIDTH-1:0] crit_data_q, crit_data_d;
  logic                  unused_addr;

  assign start_off   = miss_addr_i[3:2];
  assign unused_addr = ^miss_addr_i[1:0];

  // The first ack of a refill always carries the requested (critical) word.
  always_comb begin
    crit_valid_d = ack_fire && (cnt_q == 2'd0);
    crit_data_d  = crit_data_q;
    if (crit_valid_d) begin
      crit_data_d = mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
    end
  end

  assign crit_valid_o = crit_valid_q;
  assign crit_data_o  = crit_data_q;
`else
  logic unused_addr;

  assign start_off    = 2'd0;
  assign unused_addr  = ^miss_addr_i[3:0];
  assign crit_valid_o = 1'b0;
  assign crit_data_o  = '0;
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    unique case (state_q)
      StIdle: begin
        if (miss_req_i) begin
          base_d  = miss_addr_i[ADDRESS_WIDTH-1:4];
          off_d   = start_off;
          cnt_d   = 2'd0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (mem_ack_i) begin
          // Slot chosen by word offset, so the line layout is independent of fetch order.
          for (int unsigned w = 0; w < WORDS_PER_LINE; w++) begin
            if (off_q == 2'(w)) begin
              line_d[w*DATA_WIDTH +: DATA_WIDTH] = mem_rdata_i;
            end
          end
          off_d = off_q + 2'd1;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = StFill;
          end
        end
      end
      StFill: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      base_q  <= '0;
      off_q   <= 2'd0;
      cnt_q   <= 2'd0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

  assign busy_o       = (state_q != StIdle);
  assign stall_o      = busy_o | miss_req_i;
  assign mem_req_o    = (state_q == StFetch);
  assign mem_addr_o   = {base_q, off_q, 2'b00};
  assign fill_valid_o = (state_q == StFill);
  assign fill_tag_o   = base_q[BaseWidth-1 -: TAG_WIDTH];
  assign fill_index_o = base_q[INDEX_WIDTH-1:0];
  assign fill_line_o  = line_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl; memory word at address A is {16'hBEEF, A}.
module tb_cache_refill_ctrl;

  logic         clk;
  logic         rst;
  logic         miss_req;
  logic [15:0]  miss_addr;
  logic         stall;
  logic         busy;
  logic         mem_req;
  logic [15:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         fill_valid;
  logic [7:0]   fill_tag;
  logic [3:0]   fill_index;
  logic [127:0] fill_line;
  logic         crit_valid;
  logic [31:0]  crit_data;

  int checks = 0;
  int errors = 0;

  cache_refill_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .miss_req_i   (miss_req),
    .miss_addr_i  (miss_addr),
    .stall_o      (stall),
    .busy_o       (busy),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata),
    .fill_valid_o (fill_valid),
    .fill_tag_o   (fill_tag),
    .fill_index_o (fill_index),
    .fill_line_o  (fill_line),
    .crit_valid_o (crit_valid),
    .crit_data_o  (crit_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; miss_req = 1'b0; miss_addr = 16'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    #1;
    checks++;
    if ({busy, mem_req, fill_valid, crit_valid, stall} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000",
               {busy, mem_req, fill_valid, crit_valid, stall});
    end
    checks++;
    if ({mem_addr, fill_tag, fill_index, crit_data} !== 60'h0) begin
      errors++;
      $display("FAIL reset_values got %h exp 0", {mem_addr, fill_tag, fill_index, crit_data});
    end
    checks++;
    if (fill_line !== 128'h0) begin
      errors++; $display("FAIL reset_line got %h exp 0", fill_line);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_idle_ack();
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      #1;
      checks++;
      if ({busy, mem_req, fill_valid, stall} !== 4'b0) begin
        errors++;
        $display("FAIL idle_ack_flags got %b exp 0000", {busy, mem_req, fill_valid, stall});
      end
      checks++;
      if ({mem_addr, fill_line} !== 144'h0) begin
        errors++; $display("FAIL idle_ack_data got %h exp 0", {mem_addr, fill_line});
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [1:0]  st;
    logic [15:0] a;
`ifdef CRITICAL_WORD_FIRST_EN
    st = 2'd1;
`else
    st = 2'd0;
`endif
    miss_req = 1'b1; miss_addr = 16'h1234; mem_ack = 1'b0;
    #1;
    checks++;
    if ({stall, busy, mem_req} !== 3'b100) begin
      errors++; $display("FAIL zw_cycle0 got %b exp 100", {stall, busy, mem_req});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      miss_req = 1'b0;
      a = {12'h123, 2'(st + 2'(i)), 2'b00};
      #1;
      checks++;
      if ({mem_req, busy, mem_addr} !== {2'b11, a}) begin
        errors++;
        $display("FAIL zw_fetch%0d got req=%b busy=%b addr=%h exp 1 1 %h", i, mem_req, busy,
                 mem_addr, a);
      end
      mem_ack = 1'b1; mem_rdata = {16'hBEEF, a};
    end
    tick();
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({fill_valid, mem_req, stall, fill_tag, fill_index} !== {3'b101, 8'h12, 4'h3}) begin
      errors++;
      $display("FAIL zw_fill got v=%b req=%b stall=%b tag=%h idx=%h exp 1 0 1 12 3", fill_valid,
               mem_req, stall, fill_tag, fill_index);
    end
    checks++;
    if (fill_line !== 128'hBEEF123C_BEEF1238_BEEF1234_BEEF1230) begin
      errors++; $display("FAIL zw_line got %h exp BEEF123CBEEF1238BEEF1234BEEF1230", fill_line);
    end
    tick();
    #1;
    checks++;
    if ({fill_valid, busy, stall} !== 3'b000) begin
      errors++; $display("FAIL zw_done got %b exp 000", {fill_valid, busy, stall});
    end
  endtask

  task automatic test_wait_states();
    logic [15:0] a;
    logic        ack;
    int          cyc;
    int          w;
    int          pulses;
    miss_req = 1'b1; miss_addr = 16'h1230; mem_ack = 1'b0;
    w = 0; pulses = 0;
    // Cycles 1..7: word 0 acked at 1, word 1 waits through 2..4, acked at 5, then 6 and 7.
    for (cyc = 1; cyc <= 7; cyc++) begin
      tick();
      miss_req = 1'b0;
      a = 16'h1230 + 16'(4 * w);
      ack = !(cyc >= 2 && cyc <= 4);
      #1;
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, a}) begin
        errors++;
        $display("FAIL ws_cycle%0d got req=%b addr=%h exp 1 %h", cyc, mem_req, mem_addr, a);
      end
      if (fill_valid) pulses++;
      mem_ack = ack; mem_rdata = {16'hBEEF, a};
      if (ack) w++;
    end
    tick();
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({fill_valid, fill_line} !== {1'b1, 128'hBEEF123C_BEEF1238_BEEF1234_BEEF1230}) begin
      errors++; $display("FAIL ws_fill8 got v=%b line=%h exp 1", fill_valid, fill_line);
    end
    if (fill_valid) pulses++;
    tick();
    #1;
    if (fill_valid) pulses++;
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL ws_pulse_count got %0d exp 1", pulses);
    end
  endtask

  task automatic test_crit_word();
    logic [1:0]  st;
    logic [15:0] a;
    logic        exp_cv;
    logic [31:0] exp_cd;
    logic        cw_en;
`ifdef CRITICAL_WORD_FIRST_EN
    st = 2'd2; cw_en = 1'b1; exp_cd = 32'hBEEF12A8;
`else
    st = 2'd0; cw_en = 1'b0; exp_cd = 32'h0;
`endif
    miss_req = 1'b1; miss_addr = 16'h12A8; mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      miss_req = 1'b0;
      a = {12'h12A, 2'(st + 2'(i)), 2'b00};
      exp_cv = cw_en && (i == 1);
      #1;
      checks++;
      if ({mem_addr, crit_valid} !== {a, exp_cv}) begin
        errors++;
        $display("FAIL cw_fetch%0d got addr=%h cv=%b exp %h %b", i, mem_addr, crit_valid, a,
                 exp_cv);
      end
      if (i == 1) begin
        checks++;
        if (crit_data !== exp_cd) begin
          errors++; $display("FAIL cw_data got %h exp %h", crit_data, exp_cd);
        end
      end
      mem_ack = 1'b1; mem_rdata = {16'hBEEF, a};
    end
    tick();
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({fill_valid, crit_valid, fill_tag, fill_index, fill_line[95:64]} !==
        {2'b10, 8'h12, 4'hA, 32'hBEEF12A8}) begin
      errors++;
      $display("FAIL cw_fill got v=%b cv=%b tag=%h idx=%h w2=%h exp 1 0 12 a beef12a8",
               fill_valid, crit_valid, fill_tag, fill_index, fill_line[95:64]);
    end
    checks++;
    if (fill_line !== 128'hBEEF12AC_BEEF12A8_BEEF12A4_BEEF12A0) begin
      errors++; $display("FAIL cw_line got %h exp BEEF12ACBEEF12A8BEEF12A4BEEF12A0", fill_line);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    logic [15:0] a;
    miss_req = 1'b1; miss_addr = 16'h1230; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      miss_req = 1'b0;
      a = 16'h1230 + 16'(4 * i);
      mem_ack = 1'b1; mem_rdata = {16'hBEEF, a};
      if (i == 2) rst = 1'b1;
    end
    tick();
    rst = 1'b0; mem_ack = 1'b0;
    #1;
    checks++;
    if ({busy, mem_req, fill_valid, stall} !== 4'b0) begin
      errors++;
      $display("FAIL abort_flags got %b exp 0000", {busy, mem_req, fill_valid, stall});
    end
    checks++;
    if ({mem_addr, fill_line} !== 144'h0) begin
      errors++; $display("FAIL abort_cleared got %h exp 0", {mem_addr, fill_line});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++;
      if (fill_valid !== 1'b0) begin
        errors++; $display("FAIL abort_nofill%0d got %b exp 0", i, fill_valid);
      end
    end
    miss_req = 1'b1; miss_addr = 16'h4560;
    for (int i = 0; i < 4; i++) begin
      tick();
      miss_req = 1'b0;
      a = 16'h4560 + 16'(4 * i);
      mem_ack = 1'b1; mem_rdata = {16'hBEEF, a};
    end
    tick();
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({fill_valid, fill_tag, fill_index, fill_line} !==
        {1'b1, 8'h45, 4'h6, 128'hBEEF456C_BEEF4568_BEEF4564_BEEF4560}) begin
      errors++;
      $display("FAIL abort_refill got v=%b tag=%h idx=%h line=%h", fill_valid, fill_tag,
               fill_index, fill_line);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0]  st;
    logic [15:0] a;
`ifdef CRITICAL_WORD_FIRST_EN
    st = 2'd1;
`else
    st = 2'd0;
`endif
    miss_req = 1'b1; miss_addr = 16'h1234; mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) miss_addr = 16'h5670;
      a = {12'h123, 2'(st + 2'(i)), 2'b00};
      mem_ack = 1'b1; mem_rdata = {16'hBEEF, a};
    end
    tick();
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({fill_valid, stall, mem_req, fill_tag, fill_index} !== {3'b110, 8'h12, 4'h3}) begin
      errors++;
      $display("FAIL b2b_fill got v=%b stall=%b req=%b tag=%h idx=%h exp 1 1 0 12 3",
               fill_valid, stall, mem_req, fill_tag, fill_index);
    end
    tick();
    #1;
    checks++;
    if ({busy, stall, mem_req, fill_valid} !== 4'b0100) begin
      errors++;
      $display("FAIL b2b_idle got %b exp 0100", {busy, stall, mem_req, fill_valid});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      miss_req = 1'b0;
      a = 16'h5670 + 16'(4 * i);
      #1;
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, a}) begin
        errors++;
        $display("FAIL b2b_fetch%0d got req=%b addr=%h exp 1 %h", i, mem_req, mem_addr, a);
      end
      mem_ack = 1'b1; mem_rdata = {16'hBEEF, a};
    end
    tick();
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({fill_valid, fill_tag, fill_index, fill_line} !==
        {1'b1, 8'h56, 4'h7, 128'hBEEF567C_BEEF5678_BEEF5674_BEEF5670}) begin
      errors++;
      $display("FAIL b2b_second got v=%b tag=%h idx=%h line=%h", fill_valid, fill_tag,
               fill_index, fill_line);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_idle_ack();
    test_zero_wait();
    test_wait_states();
    test_crit_word();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
